// File: rtl/pc16_fetch.sv
// Hack-style 16-bit program counter with an IDLE/REQ/HALT fetch handshake.
// Optional sticky wrap flag is built only when PC16_WRAP_DETECT_EN is defined.
module pc16_fetch #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        inc,
  input  logic        clr,
  input  logic        stall,
  input  logic        fetch_ack,
  output logic [15:0] out,
  output logic        fetch_req,
  output logic        wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] out_next;
  logic [1:0]  rst_sync;
  logic        run_ok;
  logic        accept;

  // Reset is applied asynchronously but released through two flops, so the
  // FSM never leaves IDLE on an edge that races the rst_n deassertion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run_ok = rst_sync[1];
  assign accept = (state == REQ) && fetch_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      out   <= RESET_VECTOR;
    end else begin
      state <= state_next;
      out   <= out_next;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and infers a latch.
    state_next = state;
    out_next   = out;
    unique case (state)
      IDLE: begin
        if (run_ok) state_next = stall ? HALT : REQ;
      end
      REQ: begin
        if (accept) begin
          if (load)     out_next = in;
          else if (inc) out_next = out + 16'd1;
        end
        if (stall) state_next = HALT;
      end
      HALT: begin
        if (!stall) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
    // Restart wins over everything else, acknowledged or not.
    if (clr) begin
      state_next = IDLE;
      out_next   = RESET_VECTOR;
    end
  end

  // Pure state decode: no input reaches fetch_req combinationally.
  assign fetch_req = (state == REQ);

`ifdef PC16_WRAP_DETECT_EN
  logic wrap_q;
  logic inc_wraps;

  // Only an accepted increment from FFFF counts; a load of 0000 does not.
  assign inc_wraps = accept && !load && inc && (out == 16'hFFFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else if (clr) begin
      wrap_q <= 1'b0;
    end else if (inc_wraps) begin
      wrap_q <= 1'b1;
    end
  end

  assign wrap = wrap_q;
`else
  assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_pc16_fetch.sv
// Self-checking bench for pc16_fetch: directed scenarios followed by random
// traffic, all compared against a cycle-level reference model of the PC rules.
module tb_pc16_fetch;

  localparam logic [15:0] RV = 16'h0000;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic        load, inc, clr, stall, fetch_ack;
  logic [15:0] out;
  logic        fetch_req;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: 0 = idle, 1 = fetching, 2 = halted.
  int          m_mode;
  logic [15:0] m_pc;
  bit          m_wrap;
  int          m_since_rst;

  pc16_fetch #(.RESET_VECTOR(RV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .load      (load),
    .inc       (inc),
    .clr       (clr),
    .stall     (stall),
    .fetch_ack (fetch_ack),
    .out       (out),
    .fetch_req (fetch_req),
    .wrap      (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode      = 0;
    m_pc        = RV;
    m_wrap      = 1'b0;
    m_since_rst = 0;
  endtask

  // Applied at each rising edge using the inputs held during that cycle.
  task automatic model_edge();
    bit ready;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ready = (m_since_rst >= 2);
    if (m_since_rst < 2) m_since_rst++;
    if (clr) begin
      m_mode = 0;
      m_pc   = RV;
      m_wrap = 1'b0;
      return;
    end
    case (m_mode)
      0: if (ready) m_mode = stall ? 2 : 1;
      1: begin
        if (fetch_ack) begin
          if (load) m_pc = in;
          else if (inc) begin
            if (m_pc == 16'hFFFF) m_wrap = 1'b1;
            m_pc = 16'((32'(m_pc) + 1) % 65536);
          end
        end
        if (stall) m_mode = 2;
      end
      default: if (!stall) m_mode = 1;
    endcase
  endtask

  function automatic logic exp_wrap();
`ifdef PC16_WRAP_DETECT_EN
    return m_wrap;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".out"}, 32'(out), 32'(m_pc));
    check({tag, ".fetch_req"}, 32'(fetch_req), 32'(m_mode == 1));
    check({tag, ".wrap"}, 32'(wrap), 32'(exp_wrap()));
  endtask

  // One clock: inputs already driven; step the model at the edge, check at the
  // following falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic drive(input logic [15:0] a, input logic l, input logic i,
                       input logic c, input logic s, input logic k);
    in = a; load = l; inc = i; clr = c; stall = s; fetch_ack = k;
  endtask

  // rst_n pulse entirely between clock edges; outputs must drop with no edge.
  task automatic async_pulse(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all({tag, ".async"});
    #1 rst_n = 1'b1;
    cycle({tag, ".after"});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(16'h0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset, then count from the reset vector.
    repeat (3) begin
      @(negedge clk);
      check_all("reset");
    end
    drive(16'h0, 0, 1, 0, 0, 1);
    rst_n = 1'b1;
    repeat (6) cycle("count");
    check("count.value", 32'(out), 32'h0003);

    // Load beats inc.
    repeat (2) cycle("to5");
    check("to5.value", 32'(out), 32'h0005);
    drive(16'h1234, 1, 1, 0, 0, 1);
    cycle("load_beats_inc");
    check("load_beats_inc.value", 32'(out), 32'h1234);

    // Ack wait: hold for 4 cycles, then step once.
    drive(16'h0, 0, 1, 0, 0, 0);
    repeat (4) cycle("ack_wait");
    check("ack_wait.hold", 32'(out), 32'h1234);
    fetch_ack = 1'b1;
    cycle("ack_wait.go");
    check("ack_wait.step", 32'(out), 32'h1235);

    // No load, no inc: re-fetch the same address.
    inc = 1'b0;
    repeat (2) cycle("refetch");

    // Stall for 3 cycles mid-run.
    drive(16'h0, 0, 1, 0, 1, 0);
    repeat (3) cycle("stall");
    check("stall.req_low", 32'(fetch_req), 32'h0);
    stall = 1'b0;
    cycle("unstall");
    check("unstall.req_high", 32'(fetch_req), 32'h1);

    // Stall together with ack: update first, then halt.
    drive(16'h0, 0, 1, 0, 1, 1);
    cycle("stall_ack");
    stall = 1'b0;
    cycle("stall_ack.resume");

    // Wrap: load FFFF, then increment.
    drive(16'hFFFF, 1, 0, 0, 0, 1);
    cycle("wrap.load");
    drive(16'h0, 0, 1, 0, 0, 1);
    cycle("wrap.inc");
    check("wrap.value", 32'(out), 32'h0000);
    repeat (3) cycle("wrap.sticky");
    drive(16'h0000, 1, 0, 0, 0, 1);
    cycle("wrap.load0");

    // Clear overrides ack/load/stall.
    drive(16'hBEEF, 1, 1, 1, 1, 1);
    cycle("clr");
    check("clr.value", 32'(out), 32'(RV));
    check("clr.idle", 32'(fetch_req), 32'h0);
    drive(16'h0, 0, 1, 0, 0, 1);
    repeat (3) cycle("post_clr");

    // Async reset mid-cycle.
    async_pulse("pulse");
    repeat (4) cycle("post_pulse");

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      drive(16'($urandom),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 7) == 0) in = 16'hFFFF;
      if ($urandom_range(0, 199) == 0) async_pulse("rand");
      else cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
